// File: rtl/serializador_pkg.sv
// Shared types and constants for the matrix-to-UART serializer.
package serializador_pkg;

    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned DADO_W   = 16;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned ESTADO_W = 4;

    localparam logic [BYTE_W-1:0] BYTE_INICIO_PAD = 8'h23;
    localparam logic [BYTE_W-1:0] BYTE_FIM_PAD    = 8'h0A;

    typedef enum logic [ESTADO_W-1:0] {
        OCIOSO     = 4'd0,
        ENVIA_INI  = 4'd1,
        ESPERA_INI = 4'd2,
        ENDERECA   = 4'd3,
        LE         = 4'd4,
        ENVIA_MSB  = 4'd5,
        ESPERA_MSB = 4'd6,
        ENVIA_LSB  = 4'd7,
        ESPERA_LSB = 4'd8,
        PROXIMO    = 4'd9,
        ENVIA_FIM  = 4'd10,
        ESPERA_FIM = 4'd11,
        FINAL      = 4'd12
    } estado_t;

    // True for the states that hand a byte to the transmitter.
    function automatic logic eh_envia(estado_t e);
        return (e == ENVIA_INI) || (e == ENVIA_MSB) ||
               (e == ENVIA_LSB) || (e == ENVIA_FIM);
    endfunction

endpackage

// File: rtl/serializador_matriz_contador.sv
// Line/column position counter for the row-major matrix sweep.
module contador_matriz
    import serializador_pkg::*;
#(
    parameter int unsigned LINHAS  = 3,
    parameter int unsigned COLUNAS = 3
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              zera,
    input  logic              conta,
    output logic [ADDR_W-1:0] linha,
    output logic [ADDR_W-1:0] coluna,
    output logic              ultimo
);

    logic [ADDR_W-1:0] linha_prox;
    logic [ADDR_W-1:0] coluna_prox;

    // Next position: column wraps into a line step; the line wraps too so no out-of-range address appears.
    always_comb begin
        linha_prox  = linha;
        coluna_prox = coluna;
        if (zera) begin
            linha_prox  = '0;
            coluna_prox = '0;
        end else if (conta) begin
            if (coluna == ADDR_W'(COLUNAS - 1)) begin
                coluna_prox = '0;
                linha_prox  = (linha == ADDR_W'(LINHAS - 1)) ? '0 : linha + ADDR_W'(1);
            end else begin
                coluna_prox = coluna + ADDR_W'(1);
            end
        end
    end

    // Position registers; ultimo is precomputed so it is valid in the same cycle as the position.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            linha  <= '0;
            coluna <= '0;
            ultimo <= 1'b0;
        end else begin
            linha  <= linha_prox;
            coluna <= coluna_prox;
            ultimo <= (linha_prox == ADDR_W'(LINHAS - 1)) &&
                      (coluna_prox == ADDR_W'(COLUNAS - 1));
        end
    end

endmodule

// File: rtl/serializador_matriz.sv
// Streams a LINHAS x COLUNAS matrix of 16-bit words from RAM to the UART TX as one framed message.
module serializador_matriz
    import serializador_pkg::*;
#(
    parameter int unsigned       LINHAS      = 3,
    parameter int unsigned       COLUNAS     = 3,
    parameter logic [BYTE_W-1:0] BYTE_INICIO = BYTE_INICIO_PAD,
    parameter logic [BYTE_W-1:0] BYTE_FIM    = BYTE_FIM_PAD
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                iniciar,
    output logic [ADDR_W-1:0]   mem_addr_line,
    output logic [ADDR_W-1:0]   mem_addr_column,
    input  logic [DADO_W-1:0]   mem_q,
    output logic [BYTE_W-1:0]   tx_dado,
    output logic                tx_partida,
    input  logic                tx_pronto,
    output logic                ocupado,
    output logic                pronto,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t           estado;
    estado_t           estado_prox;
    logic              zera;
    logic              conta;
    logic              ultimo;
    logic [BYTE_W-1:0] tx_dado_prox;
    // Only the low byte needs storing: the high byte goes straight from mem_q into tx_dado.
    logic [BYTE_W-1:0] palavra_lsb;

    contador_matriz #(
        .LINHAS  (LINHAS),
        .COLUNAS (COLUNAS)
    ) u_contador (
        .clk    (clk),
        .clear  (clear),
        .zera   (zera),
        .conta  (conta),
        .linha  (mem_addr_line),
        .coluna (mem_addr_column),
        .ultimo (ultimo)
    );

    // State register.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) estado <= OCIOSO;
        else        estado <= estado_prox;
    end

    // Next-state, counter control and next transmit byte.
    always_comb begin
        estado_prox  = estado;
        zera         = 1'b0;
        conta        = 1'b0;
        tx_dado_prox = tx_dado;
        case (estado)
            OCIOSO:     if (iniciar) begin
                            estado_prox = ENVIA_INI;
                            zera        = 1'b1;
                        end
            ENVIA_INI:  estado_prox = ESPERA_INI;
            ESPERA_INI: if (tx_pronto) estado_prox = ENDERECA;
            ENDERECA:   estado_prox = LE;
            LE:         estado_prox = ENVIA_MSB;
            ENVIA_MSB:  estado_prox = ESPERA_MSB;
            ESPERA_MSB: if (tx_pronto) estado_prox = ENVIA_LSB;
            ENVIA_LSB:  estado_prox = ESPERA_LSB;
            ESPERA_LSB: if (tx_pronto) estado_prox = PROXIMO;
            PROXIMO:    begin
                            conta       = 1'b1;
                            estado_prox = ultimo ? ENVIA_FIM : ENDERECA;
                        end
            ENVIA_FIM:  estado_prox = ESPERA_FIM;
            ESPERA_FIM: if (tx_pronto) estado_prox = FINAL;
            FINAL:      estado_prox = OCIOSO;
            default:    estado_prox = OCIOSO;
        endcase
        case (estado_prox)
            ENVIA_INI: tx_dado_prox = BYTE_INICIO;
            ENVIA_MSB: tx_dado_prox = mem_q[15:8];
            ENVIA_LSB: tx_dado_prox = palavra_lsb;
            ENVIA_FIM: tx_dado_prox = BYTE_FIM;
            default:   tx_dado_prox = tx_dado;
        endcase
    end

    // Registered outputs derived from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            tx_dado     <= '0;
            tx_partida  <= 1'b0;
            ocupado     <= 1'b0;
            pronto      <= 1'b0;
            palavra_lsb <= '0;
        end else begin
            tx_dado    <= tx_dado_prox;
            tx_partida <= eh_envia(estado_prox);
            ocupado    <= (estado_prox != OCIOSO) && (estado_prox != FINAL);
            pronto     <= (estado_prox == FINAL);
            if (estado == LE) palavra_lsb <= mem_q[7:0];
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_serializador_matriz.sv
// Directed self-checking bench for serializador_matriz with RAM and UART TX models.
module tb_serializador_matriz;

    logic        clk = 1'b0;
    logic        clear;
    logic        iniciar;
    logic [1:0]  mem_addr_line;
    logic [1:0]  mem_addr_column;
    logic [15:0] mem_q;
    logic [7:0]  tx_dado;
    logic        tx_partida;
    logic        tx_pronto;
    logic        ocupado;
    logic        pronto;
    logic [3:0]  db_estado;

    always #5 clk = ~clk;

    serializador_matriz dut (
        .clk             (clk),
        .clear           (clear),
        .iniciar         (iniciar),
        .mem_addr_line   (mem_addr_line),
        .mem_addr_column (mem_addr_column),
        .mem_q           (mem_q),
        .tx_dado         (tx_dado),
        .tx_partida      (tx_partida),
        .tx_pronto       (tx_pronto),
        .ocupado         (ocupado),
        .pronto          (pronto),
        .db_estado       (db_estado)
    );

    logic [15:0] ram [3][3];
    logic [7:0]  esperado [20];

    int n_testes = 0;
    int n_falhas = 0;

    logic [7:0] bytes_q [$];
    logic [3:0] enderecos_q [$];
    int  atraso        = 5;
    bit  modo_coincide = 1'b0;
    int  idx_longo     = -1;
    int  cnt_tx        = 0;
    int  n_pronto      = 0;
    int  n_ocup_erro   = 0;
    int  erros_le      = 0;
    int  viu_end3      = 0;
    logic [3:0] end_ref = '0;

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado_v);
        n_testes++;
        if (obtido !== esperado_v) begin
            n_falhas++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obtido, esperado_v);
        end
    endtask

    // RAM model: one-cycle read latency from the address seen before the edge.
    initial begin
        logic [1:0] la, ca;
        mem_q = '0;
        forever begin
            @(negedge clk);
            la = mem_addr_line;
            ca = mem_addr_column;
            @(posedge clk);
            #1;
            mem_q = (la < 2'd3 && ca < 2'd3) ? ram[la][ca] : 16'h0000;
        end
    end

    // TX model: records each accepted byte and answers tx_pronto after a programmable delay.
    initial begin
        tx_pronto = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_pronto = 1'b0;
            if (!clear) begin
                cnt_tx = 0;
            end else begin
                if (cnt_tx > 0) begin
                    cnt_tx--;
                    if (cnt_tx == 0) tx_pronto = 1'b1;
                end
                if (tx_partida) begin
                    bytes_q.push_back(tx_dado);
                    if (modo_coincide) begin
                        tx_pronto = 1'b1;
                        cnt_tx    = 1;
                    end else if (bytes_q.size() == idx_longo) begin
                        cnt_tx = 1000;
                    end else begin
                        cnt_tx = atraso;
                    end
                end
            end
        end
    end

    // Observer: pronto pulses, address sweep and address hold through ENDERECA/LE.
    initial begin
        forever begin
            @(negedge clk);
            if (pronto) begin
                n_pronto++;
                if (ocupado) n_ocup_erro++;
            end
            if (mem_addr_line == 2'd3 || mem_addr_column == 2'd3) viu_end3++;
            if (db_estado == 4'd3) begin
                end_ref = {mem_addr_line, mem_addr_column};
                enderecos_q.push_back(end_ref);
            end
            if (db_estado == 4'd4 && {mem_addr_line, mem_addr_column} != end_ref) erros_le++;
        end
    end

    task automatic limpa;
        bytes_q.delete();
        enderecos_q.delete();
        n_pronto    = 0;
        n_ocup_erro = 0;
        erros_le    = 0;
        viu_end3    = 0;
    endtask

    task automatic pulsa_iniciar;
        @(negedge clk);
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
    endtask

    task automatic espera_fim(input string tag, input int limite);
        int k;
        int base;
        k    = 0;
        base = n_pronto;
        while (n_pronto == base && k < limite) begin
            @(negedge clk);
            k++;
        end
        verifica({tag, "_fim"}, 32'(n_pronto != base), 32'd1);
    endtask

    task automatic espera_bytes(input string tag, input int n, input int limite);
        int k;
        k = 0;
        while (bytes_q.size() < n && k < limite) begin
            @(negedge clk);
            k++;
        end
        verifica({tag, "_espera"}, 32'(bytes_q.size() >= n), 32'd1);
    endtask

    task automatic confere_quadro(input string tag);
        verifica({tag, "_nbytes"}, 32'(bytes_q.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < bytes_q.size())
                verifica($sformatf("%s_b%0d", tag, i), 32'(bytes_q[i]), 32'(esperado[i]));
        end
    endtask

    initial begin
        ram[0][0] = 16'hAAAA; ram[0][1] = 16'hBBBB; ram[0][2] = 16'hCCCC;
        ram[1][0] = 16'hDDDD; ram[1][1] = 16'hEEEE; ram[1][2] = 16'hFFFF;
        ram[2][0] = 16'h1111; ram[2][1] = 16'h2222; ram[2][2] = 16'h3333;
        esperado = '{8'h23, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD, 8'hEE,
                     8'hEE, 8'hFF, 8'hFF, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h0A};

        clear   = 1'b0;
        iniciar = 1'b0;
        repeat (3) @(negedge clk);
        verifica("rst_estado",  32'(db_estado), 32'd0);
        verifica("rst_dado",    32'(tx_dado), 32'd0);
        verifica("rst_partida", 32'(tx_partida), 32'd0);
        verifica("rst_ocupado", 32'(ocupado), 32'd0);
        verifica("rst_pronto",  32'(pronto), 32'd0);
        verifica("rst_addr",    32'({mem_addr_line, mem_addr_column}), 32'd0);
        clear = 1'b1;
        repeat (2) @(negedge clk);

        // Normal frame.
        limpa();
        pulsa_iniciar();
        verifica("ini_partida", 32'(tx_partida), 32'd1);
        verifica("ini_dado",    32'(tx_dado), 32'h23);
        verifica("ini_ocupado", 32'(ocupado), 32'd1);
        verifica("ini_estado",  32'(db_estado), 32'd1);
        espera_fim("normal", 2000);
        repeat (3) @(negedge clk);
        confere_quadro("normal");
        verifica("normal_npronto", 32'(n_pronto), 32'd1);
        verifica("normal_ocup_em_pronto", 32'(n_ocup_erro), 32'd0);
        verifica("normal_ocup_final", 32'(ocupado), 32'd0);
        verifica("normal_nend", 32'(enderecos_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < enderecos_q.size())
                verifica($sformatf("end_%0d", i), 32'(enderecos_q[i]), 32'({2'(i / 3), 2'(i % 3)}));
        end
        verifica("end_hold_le", 32'(erros_le), 32'd0);
        verifica("end_sem_3", 32'(viu_end3), 32'd0);

        // iniciar during byte 7 is ignored.
        limpa();
        pulsa_iniciar();
        espera_bytes("reinicio", 7, 2000);
        pulsa_iniciar();
        espera_fim("reinicio", 2000);
        repeat (100) @(negedge clk);
        confere_quadro("reinicio");
        verifica("reinicio_npronto", 32'(n_pronto), 32'd1);
        verifica("reinicio_estado", 32'(db_estado), 32'd0);

        // tx_pronto coincident with tx_partida is ignored, the next one advances.
        modo_coincide = 1'b1;
        limpa();
        pulsa_iniciar();
        espera_fim("coincide", 2000);
        repeat (5) @(negedge clk);
        confere_quadro("coincide");
        modo_coincide = 1'b0;

        // Asynchronous clear during ESPERA_LSB of word (1,1).
        limpa();
        pulsa_iniciar();
        begin
            int k;
            k = 0;
            while (!(db_estado == 4'd8 && mem_addr_line == 2'd1 && mem_addr_column == 2'd1) && k < 2000) begin
                @(negedge clk);
                k++;
            end
            verifica("clear_alvo", 32'(k < 2000), 32'd1);
        end
        #2;
        clear = 1'b0;
        #1;
        verifica("clear_estado",  32'(db_estado), 32'd0);
        verifica("clear_dado",    32'(tx_dado), 32'd0);
        verifica("clear_partida", 32'(tx_partida), 32'd0);
        verifica("clear_ocupado", 32'(ocupado), 32'd0);
        verifica("clear_addr",    32'({mem_addr_line, mem_addr_column}), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        repeat (20) @(negedge clk);
        verifica("clear_nbytes",  32'(bytes_q.size()), 32'd11);
        verifica("clear_npronto", 32'(n_pronto), 32'd0);
        limpa();
        pulsa_iniciar();
        espera_fim("pos_clear", 2000);
        repeat (3) @(negedge clk);
        confere_quadro("pos_clear");

        // tx_pronto withheld 1000 cycles on the 4th byte.
        idx_longo = 4;
        limpa();
        pulsa_iniciar();
        espera_bytes("longo", 4, 2000);
        repeat (500) @(negedge clk);
        verifica("longo_estado",  32'(db_estado), 32'd6);
        verifica("longo_dado",    32'(tx_dado), 32'hBB);
        verifica("longo_partida", 32'(tx_partida), 32'd0);
        verifica("longo_nbytes",  32'(bytes_q.size()), 32'd4);
        espera_fim("longo", 3000);
        repeat (3) @(negedge clk);
        confere_quadro("longo");
        idx_longo = -1;

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule

// File: doc/serializador_matriz.md
# serializador_matriz

Reads a 3x3 matrix of 16-bit words from the face RAM and streams it byte-by-byte to the UART transmitter as one framed message. Sits between the face RAM (read port) and the serial TX unit in the transmission path. One `iniciar` pulse produces one frame: a start byte, 18 data bytes (row-major, MSB first), and an end byte.

## Interface

- `LINHAS`, default 3: matrix lines.
- `COLUNAS`, default 3: matrix columns.
- `BYTE_INICIO`, default 8'h23: frame start byte (`#`).
- `BYTE_FIM`, default 8'h0A: frame end byte (LF).
- `clk`, in, 1: single clock; all logic on posedge.
- `clear`, in, 1: reset, asynchronous, active-low.
- `iniciar`, in, 1: start request, sampled only in `OCIOSO`.
- `mem_addr_line`, out, 2: RAM line address.
- `mem_addr_column`, out, 2: RAM column address.
- `mem_q`, in, 16: RAM read data.
- `tx_dado`, out, 8: byte to transmit.
- `tx_partida`, out, 1: one-cycle pulse; TX must accept `tx_dado`.
- `tx_pronto`, in, 1: one-cycle pulse from TX; current byte finished.
- `ocupado`, out, 1: high from the cycle after accepted `iniciar` until `pronto`.
- `pronto`, out, 1: one-cycle pulse at end of frame.
- `db_estado`, out, 4: current state encoding.

## Operation

- States: `OCIOSO`, `ENVIA_INI`, `ESPERA_INI`, `ENDERECA`, `LE`, `ENVIA_MSB`, `ESPERA_MSB`, `ENVIA_LSB`, `ESPERA_LSB`, `PROXIMO`, `ENVIA_FIM`, `ESPERA_FIM`, `FINAL`.
- Transitions:
  - `OCIOSO` goes to `ENVIA_INI` on `iniciar`; line/column counters clear to 0.
  - `ENVIA_INI` goes to `ESPERA_INI`. `ESPERA_INI` goes to `ENDERECA` on `tx_pronto`.
  - `ENDERECA` goes to `LE` (RAM latches the address). `LE` goes to `ENVIA_MSB`; `mem_q` is captured into the word register on the edge leaving `LE`.
  - `ENVIA_MSB` goes to `ESPERA_MSB`, then to `ENVIA_LSB` on `tx_pronto`. `ENVIA_LSB` goes to `ESPERA_LSB`, then to `PROXIMO` on `tx_pronto`.
  - `PROXIMO` increments the column. On column wrap (`COLUNAS-1` to 0) it increments the line. It goes to `ENDERECA`, or to `ENVIA_FIM` if position (`LINHAS-1`, `COLUNAS-1`) was just sent.
  - `ENVIA_FIM` goes to `ESPERA_FIM`, then to `FINAL` on `tx_pronto`. `FINAL` goes to `OCIOSO`.
- `tx_dado` per state:
  - `BYTE_INICIO` in `*_INI`.
  - word[15:8] in `*_MSB`.
  - word[7:0] in `*_LSB`.
  - `BYTE_FIM` in `*_FIM`.
  - Registered, stable from the `ENVIA_*` cycle until `tx_pronto`.
- `tx_partida` is high only in `ENVIA_*` states. `tx_pronto` is ignored outside `ESPERA_*` states.
- The address outputs follow the counters, held stable from `ENDERECA` through `LE`.
- `iniciar` while `ocupado` is ignored and not queued.
- Reset values (`clear` low, any state): state `OCIOSO`, counters 0, word register 0, `tx_dado` 0, `tx_partida` 0, `ocupado` 0, `pronto` 0, addresses 0. Reset mid-frame aborts the frame and emits no end byte.

## Timing

- From `iniciar` high in `OCIOSO` at cycle n: `tx_partida` is high in cycle n+1.
- RAM read latency: 1 cycle. The address registered at the end of `ENDERECA` gives valid `mem_q` during `LE`.
- Per word, excluding TX time: 2 cycles (`ENDERECA`, `LE`) + 2 `ENVIA` + 2 waits (≥1 each) + 1 `PROXIMO`.
- Frame: exactly 20 `tx_partida` pulses.
- `pronto` is high in `FINAL`, one cycle after the end byte's `tx_pronto`. `ocupado` drops in the same cycle.
- `tx_pronto` coincident with `tx_partida` is not accepted; only pulses arriving in `ESPERA_*` advance the FSM.

## Structure

- Package `serializador_pkg`:
  - State enum (4-bit encoding matching `db_estado`).
  - `BYTE_INICIO`/`BYTE_FIM` defaults.
  - Address widths.
- Sub-module `contador_matriz`:
  - Line/column counter with synchronous zero, enable, and a column-wrap line increment.
  - Outputs `ultimo` at (`LINHAS-1`, `COLUNAS-1`).

## Test plan

- RAM rows {AAAA,BBBB,CCCC},{DDDD,EEEE,FFFF},{1111,2222,3333}; TX model answers `tx_pronto` 5 cycles after each `tx_partida`; one `iniciar` -> byte stream 23,AA,AA,BB,BB,CC,CC,DD,DD,EE,EE,FF,FF,11,11,22,22,33,33,0A, then one `pronto` pulse, `ocupado` low.
- Address sweep check -> (line,column) pairs (0,0),(0,1),(0,2),(1,0)…(2,2), each held through `ENDERECA`/`LE`; no address 3 ever driven.
- `iniciar` pulsed again during byte 7 -> ignored; exactly 20 bytes; no second frame.
- `tx_pronto` asserted in the same cycle as `tx_partida`, and again 1 cycle later -> only the later pulse advances; no byte skipped.
- `clear` low during `ESPERA_LSB` of word (1,1) -> all outputs 0 and `OCIOSO` asynchronously; next `iniciar` restarts with 23,AA,AA.
- `tx_pronto` held off 1000 cycles -> FSM waits in `ESPERA_*`, `tx_dado` unchanged, no extra `tx_partida`.
